// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external combinational 3-operand adder between two requesters.
// Optional per-requester statistics counters are enabled by defining ADDER_ARB_STATS_EN.
module adder_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_op1,
    input  logic [2*DATA_WIDTH-1:0] req_op2,
    input  logic [2*DATA_WIDTH-1:0] req_op3,
    input  logic [1:0]              req_cin,
    output logic [1:0]              resp_valid,
    input  logic [1:0]              resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_result,
    output logic                    resp_cout,
    output logic [DATA_WIDTH-1:0]   add_op1,
    output logic [DATA_WIDTH-1:0]   add_op2,
    output logic [DATA_WIDTH-1:0]   add_op3,
    output logic                    add_cin,
    input  logic [DATA_WIDTH-1:0]   add_result,
    input  logic                    add_cout,
    output logic                    busy,
    output logic [1:0]              dbg_state
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]    done_cnt0,
    output logic [CNT_WIDTH-1:0]    done_cnt1,
    output logic [CNT_WIDTH-1:0]    conflict_cnt
`endif
);

    // Handshakes: a request transfers on a clock edge where req_valid[i] && req_ready[i];
    // a response transfers on an edge where resp_valid[i] && resp_ready[i].
    // dbg_state encoding: 0 = IDLE, 1 = EXEC, 2 = RESP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] add_op1_q, add_op1_d;
    logic [DATA_WIDTH-1:0] add_op2_q, add_op2_d;
    logic [DATA_WIDTH-1:0] add_op3_q, add_op3_d;
    logic                  add_cin_q, add_cin_d;
    logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
    logic                  resp_cout_q, resp_cout_d;
    logic                  arb_g;
    logic                  resp_done;

    if (CNT_WIDTH < 1 || DATA_WIDTH < 1) begin : g_param_check
        $error("adder_arbiter: DATA_WIDTH and CNT_WIDTH must be positive");
    end

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        case (req_valid)
            2'b01:   arb_g = 1'b0;
            2'b10:   arb_g = 1'b1;
            default: arb_g = ~last_grant_q;
        endcase
    end

    assign resp_done = (state_q == RESP) && resp_ready[grant_q];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        add_op1_d     = add_op1_q;
        add_op2_d     = add_op2_q;
        add_op3_d     = add_op3_q;
        add_cin_d     = add_cin_q;
        resp_result_d = resp_result_q;
        resp_cout_d   = resp_cout_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d   = arb_g;
                    add_op1_d = arb_g ? req_op1[2*DATA_WIDTH-1:DATA_WIDTH] : req_op1[DATA_WIDTH-1:0];
                    add_op2_d = arb_g ? req_op2[2*DATA_WIDTH-1:DATA_WIDTH] : req_op2[DATA_WIDTH-1:0];
                    add_op3_d = arb_g ? req_op3[2*DATA_WIDTH-1:DATA_WIDTH] : req_op3[DATA_WIDTH-1:0];
                    add_cin_d = req_cin[arb_g];
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                resp_result_d = add_result;
                resp_cout_d   = add_cout;
                state_d       = RESP;
            end
            RESP: begin
                if (resp_done) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            add_op1_q     <= '0;
            add_op2_q     <= '0;
            add_op3_q     <= '0;
            add_cin_q     <= 1'b0;
            resp_result_q <= '0;
            resp_cout_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            add_op1_q     <= add_op1_d;
            add_op2_q     <= add_op2_d;
            add_op3_q     <= add_op3_d;
            add_cin_q     <= add_cin_d;
            resp_result_q <= resp_result_d;
            resp_cout_q   <= resp_cout_d;
        end
    end

    // req_ready is held low during reset so nothing is acknowledged that will be dropped.
    assign req_ready   = (state_q == IDLE && (|req_valid) && !reset) ? (arb_g ? 2'b10 : 2'b01) : 2'b00;
    assign resp_valid  = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_result = resp_result_q;
    assign resp_cout   = resp_cout_q;
    assign add_op1     = add_op1_q;
    assign add_op2     = add_op2_q;
    assign add_op3     = add_op3_q;
    assign add_cin     = add_cin_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state   = state_q;

`ifdef ADDER_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] done0_q, done1_q, conflict_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            done0_q    <= '0;
            done1_q    <= '0;
            conflict_q <= '0;
        end else begin
            if (resp_done && !grant_q) done0_q <= done0_q + CNT_WIDTH'(1);
            if (resp_done && grant_q)  done1_q <= done1_q + CNT_WIDTH'(1);
            if (state_q == IDLE && req_valid == 2'b11) conflict_q <= conflict_q + CNT_WIDTH'(1);
        end
    end

    assign done_cnt0    = done0_q;
    assign done_cnt1    = done1_q;
    assign conflict_cnt = conflict_q;
`endif

endmodule
